// File: rtl/piq_pkg.sv
// Shared defaults and helpers for the parameterised instruction queue.
package piq_pkg;

    localparam int unsigned       PIQ_WIDTH    = 12;
    localparam int unsigned       PIQ_OPC_W    = 3;
    localparam logic [PIQ_OPC_W-1:0] PIQ_HALT_OPC = 3'b111;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int unsigned piq_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/piq_ptr.sv
// Modulo-DEPTH incrementing pointer with synchronous clear and async active-low reset.
module piq_ptr #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int unsigned AW = $clog2(DEPTH);

    // DEPTH is a power of two, so natural overflow gives the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + AW'(1);
        end
    end

endmodule

// File: rtl/param_instr_queue.sv
// Instruction FIFO with optional halt-opcode detection (macro PIQ_HALT_DETECT_EN).
module param_instr_queue
    import piq_pkg::*;
#(
    parameter int unsigned          WIDTH    = PIQ_WIDTH,
    parameter int unsigned          DEPTH    = 8,
    parameter int unsigned          OPC_W    = PIQ_OPC_W,
    parameter logic [OPC_W-1:0]     HALT_OPC = OPC_W'(PIQ_HALT_OPC)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [piq_cnt_w(DEPTH)-1:0]    count,
    output logic                           halted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = piq_cnt_w(DEPTH);

`ifdef PIQ_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             push_acc;
    logic             pop;
    logic             is_halt;
    logic             store;

    assign in_ready  = (count != CW'(DEPTH)) && !halted;
    assign out_valid = (count != '0);
    assign out_data  = mem[head];

    assign push_acc = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign is_halt  = HALT_EN && (in_data[WIDTH-1 -: OPC_W] == HALT_OPC);
    // A halt word is consumed by the handshake but never occupies a slot.
    assign store    = push_acc && !is_halt;

    piq_ptr #(.DEPTH(DEPTH)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .inc   (pop),
        .ptr   (head)
    );

    piq_ptr #(.DEPTH(DEPTH)) u_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .inc   (store),
        .ptr   (tail)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (store && !flush) begin
            mem[tail] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (store && !pop) begin
            count <= count + CW'(1);
        end else if (!store && pop) begin
            count <= count - CW'(1);
        end
    end

`ifdef PIQ_HALT_DETECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (flush) begin
            halted <= 1'b0;
        end else if (push_acc && is_halt) begin
            halted <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_param_instr_queue.sv
// Directed self-checking bench for param_instr_queue (default parameters).
module tb_param_instr_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [3:0]  count;
    logic        halted;

    int unsigned n_vec;
    int unsigned n_err;

    param_instr_queue #(
        .WIDTH (12),
        .DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given handshake inputs, released 1ns after the edge.
    task automatic cycle(input logic push, input logic [11:0] data, input logic popr,
                         input logic fl);
        @(negedge clk);
        in_valid  = push;
        in_data   = data;
        out_ready = popr;
        flush     = fl;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [11:0] exp);
        @(negedge clk);
        check(tag, {20'h0, out_data}, {20'h0, exp});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [11:0] model [$];
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_count", {28'h0, count}, 32'd0);
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_out_data", {20'h0, out_data}, 32'd0);
        check("rst_in_ready", {31'h0, in_ready}, 32'd1);
        check("rst_halted", {31'h0, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, 9th word dropped
        for (int i = 1; i <= 8; i++) cycle(1'b1, 12'(i), 1'b0, 1'b0);
        check("fill_count", {28'h0, count}, 32'd8);
        check("fill_in_ready", {31'h0, in_ready}, 32'd0);
        cycle(1'b1, 12'h009, 1'b0, 1'b0);
        check("full_drop_count", {28'h0, count}, 32'd8);
        check("full_head", {20'h0, out_data}, 32'h001);

        // Drain three, refill across the wrap, drain all
        for (int i = 1; i <= 3; i++) pop_check("drain_a", 12'(i));
        check("drain_count", {28'h0, count}, 32'd5);
        for (int i = 10; i <= 12; i++) cycle(1'b1, 12'(i), 1'b0, 1'b0);
        check("wrap_count", {28'h0, count}, 32'd8);
        for (int i = 4; i <= 8; i++) pop_check("drain_b", 12'(i));
        for (int i = 10; i <= 12; i++) pop_check("drain_wrap", 12'(i));
        check("empty_count", {28'h0, count}, 32'd0);
        check("empty_out_valid", {31'h0, out_valid}, 32'd0);

        // Pop while empty is ignored
        cycle(1'b0, 12'h000, 1'b1, 1'b0);
        check("underflow_count", {28'h0, count}, 32'd0);

        // No bypass: not visible before the edge, visible after
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 12'h101;
        #1;
        check("nobypass_pre", {31'h0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("nobypass_post_v", {31'h0, out_valid}, 32'd1);
        check("nobypass_post_d", {20'h0, out_data}, 32'h101);
        model.push_back(12'h101);
        for (int i = 2; i <= 4; i++) begin
            cycle(1'b1, 12'h100 + 12'(i), 1'b0, 1'b0);
            model.push_back(12'h100 + 12'(i));
        end
        check("sim_start_count", {28'h0, count}, 32'd4);

        // Simultaneous push and pop for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("sim_order", {20'h0, out_data}, {20'h0, model[0]});
            in_valid  = 1'b1;
            in_data   = 12'h111 + 12'(i);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            void'(model.pop_front());
            model.push_back(12'h111 + 12'(i));
            check("sim_count", {28'h0, count}, 32'd4);
        end
        for (int i = 0; i < 4; i++) pop_check("sim_drain", model[i]);
        model.delete();

        // Flush overrides push and pop in the same cycle
        cycle(1'b1, 12'h0AA, 1'b0, 1'b0);
        cycle(1'b1, 12'h0BB, 1'b0, 1'b0);
        cycle(1'b1, 12'h0CC, 1'b1, 1'b1);
        check("flush_count", {28'h0, count}, 32'd0);
        check("flush_out_valid", {31'h0, out_valid}, 32'd0);

`ifdef PIQ_HALT_DETECT_EN
        cycle(1'b1, 12'h123, 1'b0, 1'b0);
        cycle(1'b1, 12'hE00, 1'b0, 1'b0);
        cycle(1'b1, 12'h456, 1'b0, 1'b0);
        check("halt_count", {28'h0, count}, 32'd1);
        check("halt_flag", {31'h0, halted}, 32'd1);
        check("halt_in_ready", {31'h0, in_ready}, 32'd0);
        check("halt_head", {20'h0, out_data}, 32'h123);
        cycle(1'b0, 12'h000, 1'b0, 1'b1);
        check("halt_flush_flag", {31'h0, halted}, 32'd0);
        check("halt_flush_count", {28'h0, count}, 32'd0);
        check("halt_flush_ready", {31'h0, in_ready}, 32'd1);
`else
        cycle(1'b1, 12'hE00, 1'b0, 1'b0);
        check("nohalt_count", {28'h0, count}, 32'd1);
        check("nohalt_data", {20'h0, out_data}, 32'hE00);
        check("nohalt_flag", {31'h0, halted}, 32'd0);
        check("nohalt_in_ready", {31'h0, in_ready}, 32'd1);
        cycle(1'b0, 12'h000, 1'b0, 1'b1);
`endif

        // Reset mid-operation at count=5 with push and pop asserted
        for (int i = 1; i <= 5; i++) cycle(1'b1, 12'h200 + 12'(i), 1'b0, 1'b0);
        check("pre_rst_count", {28'h0, count}, 32'd5);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 12'h3FF;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        check("midrst_count", {28'h0, count}, 32'd0);
        check("midrst_out_valid", {31'h0, out_valid}, 32'd0);
        check("midrst_out_data", {20'h0, out_data}, 32'd0);
        check("midrst_in_ready", {31'h0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_count", {28'h0, count}, 32'd0);
        check("post_rst_out_valid", {31'h0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
